// File: rtl/ysyx_25030093_ifu.sv
// ysyx_25030093_ifu: instruction fetch unit.
// Takes a fetch request for pc, reads one 32-bit word over an AR/R
// valid/ready bus, and holds {inst, inst_pc, inst_fault} for decode until
// it is accepted. A watchdog abandons fetches stuck on the bus for TIMEOUT
// cycles (TIMEOUT = 0 disables it).
// Optional feature: define YSYX_25030093_IFU_ALIGN_CHECK_EN to fault
// misaligned pc values locally without issuing a bus transaction.
module ysyx_25030093_ifu #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        fetch_req,
  output logic        fetch_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        mem_arvalid,
  output logic [31:0] mem_araddr,
  input  logic        mem_arready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  output logic        mem_rready
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  // The watchdog fires in the cycle that brings the bus time up to TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       inst_q, inst_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wd_fire;

  // Saturating increment: the counter never wraps back to zero.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  assign wd_fire = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  // Outputs decode from state/registers only; no mem_* input reaches inst_valid.
  assign fetch_ready = (state_q == S_IDLE) | ((state_q == S_HOLD) & inst_ready);
  assign mem_arvalid = (state_q == S_AR);
  assign mem_araddr  = addr_q;
  assign mem_rready  = (state_q == S_R);
  assign inst_valid  = (state_q == S_HOLD);
  assign inst        = inst_q;
  assign inst_pc     = addr_q;
  assign inst_fault  = fault_q;

  // Next-state and datapath capture logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (fetch_ready && fetch_req) begin
          // Accept: latch the address so later pc changes cannot disturb it.
          addr_d = pc;
          cnt_d  = '0;
`ifdef YSYX_25030093_IFU_ALIGN_CHECK_EN
          if (pc[1:0] != 2'b00) begin
            state_d = S_HOLD;
            inst_d  = '0;
            fault_d = 1'b1;
          end else begin
            state_d = S_AR;
          end
`else
          state_d = S_AR;
`endif
        end else if ((state_q == S_HOLD) && inst_ready) begin
          state_d = S_IDLE;
        end
      end
      S_AR: begin
        cnt_d = cnt_inc(cnt_q);
        if (mem_arready) begin
          state_d = S_R;
        end else if (wd_fire) begin
          state_d = S_HOLD;
          inst_d  = '0;
          fault_d = 1'b1;
        end
      end
      S_R: begin
        cnt_d = cnt_inc(cnt_q);
        if (mem_rvalid) begin
          state_d = S_HOLD;
          inst_d  = mem_rdata;
          fault_d = (mem_rresp != 2'b00);
        end else if (wd_fire) begin
          state_d = S_HOLD;
          inst_d  = '0;
          fault_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      inst_q  <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// Directed testbench for ysyx_25030093_ifu. Two instances share inputs:
// dut (default TIMEOUT) for bus-level behaviour, dut8 (TIMEOUT=8) for the watchdog.
module tb_ysyx_25030093_ifu;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_req;
  logic        inst_ready;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;

  logic        fetch_ready, inst_fault, inst_valid, mem_arvalid, mem_rready;
  logic [31:0] inst, inst_pc, mem_araddr;
  logic        t_fetch_ready, t_inst_fault, t_inst_valid, t_mem_arvalid, t_mem_rready;
  logic [31:0] t_inst, t_inst_pc, t_mem_araddr;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_25030093_ifu dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req), .fetch_ready(fetch_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr),
    .mem_arready(mem_arready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_rresp(mem_rresp), .mem_rready(mem_rready)
  );

  ysyx_25030093_ifu #(.TIMEOUT(8)) dut8 (
    .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req), .fetch_ready(t_fetch_ready),
    .inst(t_inst), .inst_pc(t_inst_pc), .inst_fault(t_inst_fault), .inst_valid(t_inst_valid),
    .inst_ready(inst_ready), .mem_arvalid(t_mem_arvalid), .mem_araddr(t_mem_araddr),
    .mem_arready(mem_arready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_rresp(mem_rresp), .mem_rready(t_mem_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = '0; fetch_req = 0; inst_ready = 0;
    mem_arready = 0; mem_rvalid = 0; mem_rdata = '0; mem_rresp = '0;
    repeat (2) step();
    n_checks++; if (mem_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %0b want 0", mem_arvalid); end
    n_checks++; if (mem_rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready: got %0b want 0", mem_rready); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %0b want 0", inst_valid); end
    n_checks++; if ({inst, inst_pc, inst_fault} !== 65'd0) begin n_fail++; $display("FAIL reset_data: inst=%h pc=%h fault=%0b want 0", inst, inst_pc, inst_fault); end
    rst = 1'b0;
    #1;
    n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_ready: got %0b want 1", fetch_ready); end
  endtask

  task automatic test_basic();
    pc = 32'h8000_0000; fetch_req = 1; mem_arready = 1;
    step();  // cycle 1
    n_checks++; if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL basic_ar: arvalid=%0b addr=%h want 1/80000000", mem_arvalid, mem_araddr); end
    n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL basic_fetch_ready_busy: got %0b want 0", fetch_ready); end
    fetch_req = 0;
    step();  // cycle 2
    n_checks++; if (mem_rready !== 1'b1 || mem_arvalid !== 1'b0) begin n_fail++; $display("FAIL basic_r: rready=%0b arvalid=%0b want 1/0", mem_rready, mem_arvalid); end
    mem_rvalid = 1; mem_rdata = 32'h0000_0413; mem_rresp = 2'b00;
    step();  // cycle 3
    mem_rvalid = 0;
    n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0413 || inst_pc !== 32'h8000_0000 || inst_fault !== 1'b0)
      begin n_fail++; $display("FAIL basic_result: v=%0b inst=%h pc=%h f=%0b want 1/00000413/80000000/0", inst_valid, inst, inst_pc, inst_fault); end
    inst_ready = 1;
    step();
    inst_ready = 0;
    n_checks++; if (inst_valid !== 1'b0 || fetch_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle: v=%0b rdy=%0b want 0/1", inst_valid, fetch_ready); end
  endtask

  task automatic test_stall();
    int bad;
    mem_arready = 0; pc = 32'h8000_0010; fetch_req = 1;
    step();
    fetch_req = 0; pc = 32'h1234_5678;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0010) bad++;
      step();
    end
    n_checks++; if (bad != 0 || mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0010) begin n_fail++; $display("FAIL stall_ar_hold: bad=%0d arvalid=%0b addr=%h want 0/1/80000010", bad, mem_arvalid, mem_araddr); end
    mem_arready = 1;
    step();
    mem_arready = 0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_rready !== 1'b1 || inst_valid !== 1'b0) bad++;
      step();
    end
    n_checks++; if (bad != 0 || mem_rready !== 1'b1) begin n_fail++; $display("FAIL stall_r_wait: bad=%0d rready=%0b want 0/1", bad, mem_rready); end
    mem_rvalid = 1; mem_rdata = 32'h00A0_0093;
    step();
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      // noise on the read channel must be ignored while holding
      mem_rvalid = 1; mem_rdata = 32'hFFFF_0000 + i;
      if (inst_valid !== 1'b1 || inst !== 32'h00A0_0093 || inst_pc !== 32'h8000_0010 || fetch_ready !== 1'b0) bad++;
      step();
    end
    mem_rvalid = 0;
    n_checks++; if (bad != 0 || inst !== 32'h00A0_0093 || inst_pc !== 32'h8000_0010) begin n_fail++; $display("FAIL stall_hold: bad=%0d inst=%h pc=%h want 0/00a00093/80000010", bad, inst, inst_pc); end
    inst_ready = 1;
    #1;
    n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL stall_handshake_ready: got %0b want 1", fetch_ready); end
    step();
    inst_ready = 0;
  endtask

  task automatic test_error_back_to_back();
    pc = 32'h8000_0020; fetch_req = 1; mem_arready = 1;
    step();
    fetch_req = 0;
    step();
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF; mem_rresp = 2'b10;
    step();
    mem_rvalid = 0; mem_rresp = 2'b00;
    n_checks++; if (inst_valid !== 1'b1 || inst_fault !== 1'b1 || inst !== 32'hDEAD_BEEF || inst_pc !== 32'h8000_0020)
      begin n_fail++; $display("FAIL error_resp: v=%0b f=%0b inst=%h pc=%h want 1/1/deadbeef/80000020", inst_valid, inst_fault, inst, inst_pc); end
    inst_ready = 1; fetch_req = 1; pc = 32'h8000_0004;
    step();
    inst_ready = 0; fetch_req = 0;
    n_checks++; if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0004 || inst_valid !== 1'b0)
      begin n_fail++; $display("FAIL b2b_ar: arvalid=%0b addr=%h v=%0b want 1/80000004/0", mem_arvalid, mem_araddr, inst_valid); end
    step();
    mem_rvalid = 1; mem_rdata = 32'h0000_0011;
    step();
    mem_rvalid = 0;
    n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0011 || inst_fault !== 1'b0 || inst_pc !== 32'h8000_0004)
      begin n_fail++; $display("FAIL b2b_result: v=%0b inst=%h f=%0b pc=%h want 1/00000011/0/80000004", inst_valid, inst, inst_fault, inst_pc); end
    inst_ready = 1;
    step();
    inst_ready = 0;
  endtask

  task automatic test_timeout();
    int bad;
    rst = 1; #2; rst = 0;
    step();
    mem_arready = 0; pc = 32'h8000_0040; fetch_req = 1;
    step();
    fetch_req = 0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (t_mem_arvalid !== 1'b1 || t_inst_valid !== 1'b0) bad++;
      step();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL timeout_ar_phase: bad cycles=%0d want 0", bad); end
    n_checks++; if (t_mem_arvalid !== 1'b0 || t_inst_valid !== 1'b1 || t_inst_fault !== 1'b1 || t_inst !== 32'd0)
      begin n_fail++; $display("FAIL timeout_fire: arvalid=%0b v=%0b f=%0b inst=%h want 0/1/1/0", t_mem_arvalid, t_inst_valid, t_inst_fault, t_inst); end
    inst_ready = 1;
    step();
    inst_ready = 0; pc = 32'h8000_0080; fetch_req = 1;
    step();
    fetch_req = 0;
    step();
    n_checks++; if (t_mem_arvalid !== 1'b1 || t_inst_pc !== 32'h8000_0080) begin n_fail++; $display("FAIL timeout_second_req: arvalid=%0b pc=%h want 1/80000080", t_mem_arvalid, t_inst_pc); end
    rst = 1;
    #1;
    n_checks++; if ({t_mem_arvalid, t_mem_rready, t_inst_valid, t_inst_fault} !== 4'b0 || t_inst !== 32'd0 || t_inst_pc !== 32'd0)
      begin n_fail++; $display("FAIL async_reset: arvalid=%0b rready=%0b v=%0b f=%0b inst=%h pc=%h want all 0", t_mem_arvalid, t_mem_rready, t_inst_valid, t_inst_fault, t_inst, t_inst_pc); end
    n_checks++; if (mem_arvalid !== 1'b0 || mem_araddr !== 32'd0) begin n_fail++; $display("FAIL async_reset_main: arvalid=%0b addr=%h want 0/0", mem_arvalid, mem_araddr); end
    #2;
    rst = 0;
    step();
  endtask

  task automatic test_align();
    pc = 32'h8000_0002; fetch_req = 1; mem_arready = 1;
    step();
    fetch_req = 0;
`ifdef YSYX_25030093_IFU_ALIGN_CHECK_EN
    n_checks++; if (mem_arvalid !== 1'b0 || inst_valid !== 1'b1 || inst_fault !== 1'b1 || inst !== 32'd0 || inst_pc !== 32'h8000_0002)
      begin n_fail++; $display("FAIL align_fault: arvalid=%0b v=%0b f=%0b inst=%h pc=%h want 0/1/1/0/80000002", mem_arvalid, inst_valid, inst_fault, inst, inst_pc); end
    inst_ready = 1;
    step();
    inst_ready = 0;
`else
    n_checks++; if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0002) begin n_fail++; $display("FAIL align_passthru: arvalid=%0b addr=%h want 1/80000002", mem_arvalid, mem_araddr); end
    step();
    mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    step();
    mem_rvalid = 0;
    n_checks++; if (inst_valid !== 1'b1 || inst_fault !== 1'b0 || inst_pc !== 32'h8000_0002) begin n_fail++; $display("FAIL align_result: v=%0b f=%0b pc=%h want 1/0/80000002", inst_valid, inst_fault, inst_pc); end
    inst_ready = 1;
    step();
    inst_ready = 0;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_error_back_to_back();
    test_timeout();
    test_align();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
